// File: rtl/wall_arb_pkg.sv
// Shared constants and types for the wall-probe arbiter: the default geometry, the
// screen bounds and the off-screen test.
package wall_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int CW_DEF    = 11;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int IDX_W_DEF = $clog2(N_REQ_DEF);

    typedef logic [CW_DEF-1:0]    coord_t;
    typedef logic [IDX_W_DEF-1:0] req_idx_t;

    // Probes outside the visible screen never touch the map and always report a wall.
    function automatic logic is_offscreen(input logic [31:0] x, input logic [31:0] y);
        return (x >= 32'(SCREEN_W)) || (y >= 32'(SCREEN_H));
    endfunction

endpackage

// File: rtl/wall_probe_arbiter_rr_pick.sv
// Combinational round-robin selector. It returns the first eligible index at or
// after start_i, wrapping modulo N_REQ.
module rr_pick
    import wall_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = IDX_W_DEF
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [IW-1:0]    start_i,
    output logic             valid_o,
    output logic [IW-1:0]    idx_o
);

    logic [IW-1:0] cand_s;
    logic          take_s;

    // Scan from start_i and latch the first eligible candidate.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand_s  = '0;
        take_s  = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            cand_s  = IW'((int'(start_i) + off) % N_REQ);
            take_s  = eligible_i[cand_s] & ~valid_o;
            idx_o   = take_s ? cand_s : idx_o;
            valid_o = valid_o | take_s;
        end
    end

endmodule

// File: rtl/wall_probe_arbiter.sv
// Round-robin arbiter that shares a single wall-map read port among the player and
// the ghosts. Each request moves through a fixed 3-stage pipeline: issue, wait, return.
module wall_probe_arbiter
    import wall_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_tick_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0][CW-1:0] req_x_i,
    input  logic [N_REQ-1:0][CW-1:0] req_y_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic                     hit_o,
    output logic                     map_rd_o,
    output logic [CW-1:0]            map_x_o,
    output logic [CW-1:0]            map_y_o,
    input  logic                     map_wall_i,
    output logic                     busy_o,
    output logic [15:0]              probe_count_o,
    output logic                     overrun_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] pending_q, pending_d, eligible_s, grant_oh_s;
    logic [IW-1:0]    last_grant_q, last_grant_d, start_idx_s, pick_idx_s;
    logic             pick_valid_s;
    logic [CW-1:0]    grant_x_s, grant_y_s;
    logic             grant_oob_s;

    logic             iss_vld_q, iss_oob_q, map_rd_q, map_rd_d;
    logic [IW-1:0]    iss_tag_q;
    logic [CW-1:0]    map_x_q, map_x_d, map_y_q, map_y_d;
    logic             wt_vld_q, wt_oob_q;
    logic [IW-1:0]    wt_tag_q;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             hit_q, hit_d, busy_q, busy_d, overrun_q, overrun_d;
    logic [15:0]      probe_count_q, probe_count_d;

    assign eligible_s  = req_i & ~pending_q;
    assign start_idx_s = (last_grant_q == IW'(N_REQ - 1)) ? '0 : last_grant_q + IW'(1);

    rr_pick #(
        .N_REQ(N_REQ),
        .IW   (IW)
    ) u_pick (
        .eligible_i(eligible_s),
        .start_i   (start_idx_s),
        .valid_o   (pick_valid_s),
        .idx_o     (pick_idx_s)
    );

    // Grant, pending bookkeeping, issue-stage load and per-frame accounting
    always_comb begin
        grant_oh_s   = '0;
        grant_x_s    = req_x_i[pick_idx_s];
        grant_y_s    = req_y_i[pick_idx_s];
        grant_oob_s  = is_offscreen(32'(grant_x_s), 32'(grant_y_s));
        last_grant_d = last_grant_q;
        map_rd_d     = 1'b0;
        map_x_d      = map_x_q;
        map_y_d      = map_y_q;
        if (pick_valid_s) begin
            grant_oh_s[pick_idx_s] = 1'b1;
            last_grant_d           = pick_idx_s;
            map_rd_d               = ~grant_oob_s;
            map_x_d                = grant_x_s;
            map_y_d                = grant_y_s;
        end else begin
            grant_oh_s = '0;
        end
        // A requester is released at the edge that ends its ack cycle.
        pending_d = (pending_q & ~ack_q) | grant_oh_s;
        busy_d    = |pending_d;
        overrun_d = overrun_q | (frame_tick_i & (busy_q | (|req_i)));
        if (frame_tick_i) begin
            probe_count_d = pick_valid_s ? 16'd1 : 16'd0;
        end else if (pick_valid_s && (probe_count_q != 16'hFFFF)) begin
            probe_count_d = probe_count_q + 16'd1;
        end else begin
            probe_count_d = probe_count_q;
        end
    end

    // Return stage: use the tag to route the map result, or a forced hit, to the requester
    always_comb begin
        ack_d = '0;
        hit_d = 1'b0;
        if (wt_vld_q) begin
            ack_d[wt_tag_q] = 1'b1;
            hit_d           = wt_oob_q | map_wall_i;
        end else begin
            ack_d = '0;
            hit_d = 1'b0;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            last_grant_q  <= IW'(N_REQ - 1);
            iss_vld_q     <= 1'b0;
            iss_tag_q     <= '0;
            iss_oob_q     <= 1'b0;
            map_rd_q      <= 1'b0;
            map_x_q       <= '0;
            map_y_q       <= '0;
            wt_vld_q      <= 1'b0;
            wt_tag_q      <= '0;
            wt_oob_q      <= 1'b0;
            ack_q         <= '0;
            hit_q         <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            probe_count_q <= 16'd0;
        end else begin
            pending_q     <= pending_d;
            last_grant_q  <= last_grant_d;
            iss_vld_q     <= pick_valid_s;
            iss_tag_q     <= pick_idx_s;
            iss_oob_q     <= grant_oob_s;
            map_rd_q      <= map_rd_d;
            map_x_q       <= map_x_d;
            map_y_q       <= map_y_d;
            wt_vld_q      <= iss_vld_q;
            wt_tag_q      <= iss_tag_q;
            wt_oob_q      <= iss_oob_q;
            ack_q         <= ack_d;
            hit_q         <= hit_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            probe_count_q <= probe_count_d;
        end
    end

    assign ack_o         = ack_q;
    assign hit_o         = hit_q;
    assign map_rd_o      = map_rd_q;
    assign map_x_o       = map_x_q;
    assign map_y_o       = map_y_q;
    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;
    assign probe_count_o = probe_count_q;

endmodule

// File: doc/wall_probe_arbiter.md
WALL_PROBE_ARBITER -- requirements
Module: wall_probe_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (player, three ghosts).
REQ-002 Parameter CW, default 11: coordinate width.
REQ-003 Clk  in  1  single clock, all state on rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 frame_tick  in  1  one-cycle pulse marking frame boundary.
REQ-006 req  in  N_REQ  per-requester probe request, held until own ack.
REQ-007 req_x, req_y  in  N_REQ x CW each  probe pixel coordinates, stable while req high.
REQ-008 ack  out  N_REQ  one-cycle completion pulse per requester.
REQ-009 hit  out  1  wall result, valid only while some ack bit is high.
REQ-010 map_rd, map_x, map_y  out  1, CW, CW  registered read port to shared wall map.
REQ-011 map_wall  in  1  map result, valid exactly one cycle after map_rd.
REQ-012 busy  out  1  OR of all pending bits.
REQ-013 probe_count  out  16  grants issued in current frame.
REQ-014 overrun  out  1  sticky frame-budget violation flag.

Function
REQ-015 Eligible requester: req[i]=1 and pending[i]=0; at most one grant per cycle.
REQ-016 Round-robin: search starts at index (last_grant+1) mod N_REQ; last_grant updates only on a grant; reset value N_REQ-1, so index 0 wins first.
REQ-017 Grant at edge k: pending[i] set, coords captured; map_rd=1 with those coords during cycle k+1; map_wall sampled at edge k+2; ack[i]=1 and hit driven during cycle k+2 to k+3 (3-cycle fixed latency, req sampled to ack).
REQ-018 Pipelined: new grant every cycle allowed; up to 3 lookups in flight, each to a distinct requester; result routed by requester-index tag carried through pipeline.
REQ-019 pending[i] clears at the edge ending the ack cycle; req[i] sampled during the ack cycle is ignored; requester presents new coords from the next cycle.
REQ-020 Out-of-screen probe (x>=640 or y>=480, unsigned): map_rd stays 0 that slot, hit=1, same latency.
REQ-021 probe_count: +1 per grant, saturates at 16'hFFFF; on frame_tick loads 1 if grant same cycle, else 0.
REQ-022 overrun set when frame_tick=1 and (busy=1 or any req=1); cleared only by reset.
REQ-023 hit=0 and ack=0 in any cycle without a completing lookup.
REQ-024 Requester dropping req before ack: lookup still completes and acks; no cancel.

Reset
REQ-025 Reset_n low: ack=0, hit=0, map_rd=0, map_x=map_y=0, busy=0, probe_count=0, overrun=0, pending=0, pipeline valids=0, last_grant=N_REQ-1.
REQ-026 Reset mid-operation discards in-flight lookups; no ack issued for them after release.
REQ-027 First grant possible at first rising edge after Reset_n deasserts.

Structure
REQ-028 Package wall_arb_pkg holds N_REQ default, CW default, SCREEN_W=640, SCREEN_H=480, coord_t typedef, req_idx_t typedef.
REQ-029 Sub-module rr_pick: combinational round-robin selector (eligible vector, start index -> valid, index); instantiated once.
REQ-030 Pipeline is explicit registers: issue stage (map port, tag, oob bit), return stage (ack, hit).

Verification
REQ-031 Single requester 0 at (100,50), map_wall=1 -> map_rd cycle k+1 with (100,50), ack[0]=1, hit=1 at cycle k+2.
REQ-032 All four req high continuously -> grants ordered 0,1,2,3,0..., each requester at most one outstanding, ack spacing per requester 4 cycles.
REQ-033 Requester 2 at (640,10) -> no map_rd, ack[2] with hit=1 after 3 cycles.
REQ-034 frame_tick while requester 1 pending -> overrun=1 and stays 1; probe_count restarts at 0 (1 if same-cycle grant).
REQ-035 Reset_n pulsed low with 3 lookups in flight -> all outputs 0 immediately, no ack afterwards, next grant to index 0.
REQ-036 70000 grants in one frame -> probe_count holds 16'hFFFF.
